// File: rtl/mem_arbiter.sv
// Byte-serial arbiter sharing one RAM/IO port between instruction fetch and load/store.
// Words and halfwords are moved one byte per cycle, little-endian, with a one-cycle done pulse.
module mem_arbiter #(
  parameter logic [31:0] IO_ADDR_LO = 32'h00030000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [2:0]  mem_len,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state_q, state_d;
  logic        owner_if_q;
  logic [2:0]  len_q;
  logic [2:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rbuf_q;

  logic        accept_mem;
  logic        accept_if;
  logic        io_stall;
  logic        if_abort;
  logic [31:0] rword;

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  // The byte arriving now belongs to the address issued one cycle earlier.
  assign rword    = put_byte(rbuf_q, cnt_q[1:0] - 2'd1, ram_din);
  assign io_stall = (addr_q >= IO_ADDR_LO) && io_buffer_full;
  assign if_abort = owner_if_q && if_flush;

  assign ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
  assign ram_wr   = rdy && (state_q == WRITE) && !io_stall;
  assign if_done  = rdy && (state_q == DONE) && owner_if_q && !if_flush;
  assign mem_done = rdy && (state_q == DONE) && !owner_if_q;

  always_comb begin
    state_d    = state_q;
    accept_mem = 1'b0;
    accept_if  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          accept_mem = 1'b1;
          state_d    = mem_we ? WRITE : READ;
        end else if (if_req && !if_flush) begin
          accept_if = 1'b1;
          state_d   = READ;
        end
      end
      READ: begin
        if (if_abort)
          state_d = IDLE;
        else if (cnt_q == len_q)
          state_d = DONE;
      end
      WRITE: begin
        if (!io_stall && (cnt_q == len_q - 3'd1))
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_if_q <= 1'b0;
      len_q      <= 3'd0;
      cnt_q      <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rbuf_q     <= 32'd0;
      ram_a      <= 32'd0;
      if_data    <= 32'd0;
      mem_rdata  <= 32'd0;
    end else if (rdy) begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept_mem) begin
            owner_if_q <= 1'b0;
            len_q      <= mem_len;
            addr_q     <= mem_addr;
            wdata_q    <= mem_wdata;
            ram_a      <= mem_addr;
            cnt_q      <= 3'd0;
            rbuf_q     <= 32'd0;
          end else if (accept_if) begin
            owner_if_q <= 1'b1;
            len_q      <= 3'd4;
            addr_q     <= if_addr;
            ram_a      <= if_addr;
            cnt_q      <= 3'd0;
            rbuf_q     <= 32'd0;
          end
        end
        READ: begin
          if (!if_abort) begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q != 3'd0)
              rbuf_q <= rword;
            if (cnt_q + 3'd1 < len_q)
              ram_a <= ram_a + 32'd1;
            // Last byte lands straight in the result register so data is stable during DONE.
            if (cnt_q == len_q) begin
              if (owner_if_q)
                if_data <= rword;
              else
                mem_rdata <= rword;
            end
          end
        end
        WRITE: begin
          if (!io_stall) begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q + 3'd1 < len_q)
              ram_a <= ram_a + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level timing model fills per-cycle expectations
// that one compare process checks against the DUT on every cycle.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_flush = 1'b0;
  logic        if_done;
  logic [31:0] if_data;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [2:0]  mem_len = 3'd0;
  logic [31:0] mem_wdata = 32'd0;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din = 8'd0;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        io_buffer_full = 1'b0;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .io_buffer_full(io_buffer_full)
  );

  localparam int NC = 4096;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  int if_drop = -1;
  int mem_drop = -1;

  bit          e_ifd [NC];
  bit          e_memd[NC];
  bit          e_wr  [NC];
  bit          e_achk[NC];
  bit          e_dchk[NC];
  bit          h_rdy [NC];
  bit          h_io  [NC];
  logic [31:0] e_a   [NC];
  logic [31:0] e_data[NC];
  logic [7:0]  e_dout[NC];

  logic [7:0] ram [4096];
  logic [7:0] mdl [logic [31:0]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench RAM: one-cycle read latency, frozen with the rest of the system when rdy is low.
  always @(posedge clk) begin
    if (rdy) begin
      ram_din <= ram[ram_a[11:0]];
      if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: cycle %0d reached, required finish earlier", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h required %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && cyc < NC) begin
      chk("if_done", 32'(if_done), 32'(e_ifd[cyc]));
      chk("mem_done", 32'(mem_done), 32'(e_memd[cyc]));
      chk("ram_wr", 32'(ram_wr), 32'(e_wr[cyc]));
      if (e_achk[cyc]) chk("ram_a", ram_a, e_a[cyc]);
      if (e_wr[cyc]) chk("ram_dout", 32'(ram_dout), 32'(e_dout[cyc]));
      if (e_dchk[cyc] && e_ifd[cyc]) chk("if_data", if_data, e_data[cyc]);
      if (e_dchk[cyc] && e_memd[cyc]) chk("mem_rdata", mem_rdata, e_data[cyc]);
    end
  end

  // Logical cycle j of a transfer; logical cycle ha is stretched by hl frozen/stalled cycles.
  function automatic int rmap(input int c0, input int j, input int ha, input int hl);
    return c0 + j + ((hl > 0 && j >= ha) ? hl : 0);
  endfunction

  task automatic sched(input int c0, input bit is_if, input bit we, input logic [31:0] addr,
                       input int len, input logic [31:0] wd, input int hmode, input int ha,
                       input int hl, output int dc, output logic [31:0] data);
    logic [31:0] a;
    int rc;
    data = 32'd0;
    for (int x = 0; x < hl; x++) begin
      rc = c0 + ha + x;
      if (hmode == 1) h_rdy[rc] = 1'b1;
      if (hmode == 2) h_io[rc] = 1'b1;
      if (ha < len) begin
        e_achk[rc] = 1'b1;
        e_a[rc] = addr + 32'(ha);
      end
    end
    for (int j = 0; j < len; j++) begin
      a = addr + 32'(j);
      rc = rmap(c0, j, ha, hl);
      e_achk[rc] = 1'b1;
      e_a[rc] = a;
      if (we) begin
        e_wr[rc] = 1'b1;
        e_dout[rc] = wd[8*j +: 8];
        mdl[a] = wd[8*j +: 8];
      end else begin
        data[8*j +: 8] = mdl.exists(a) ? mdl[a] : 8'h00;
      end
    end
    dc = rmap(c0, we ? len : len + 1, ha, hl);
    if (is_if) e_ifd[dc] = 1'b1;
    else e_memd[dc] = 1'b1;
    e_dchk[dc] = !we;
    e_data[dc] = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rdy = !h_rdy[cyc];
    io_buffer_full = h_io[cyc];
    if (cyc == if_drop) if_req = 1'b0;
    if (cyc == mem_drop) mem_req = 1'b0;
  endtask

  task automatic run_to(input int last);
    while (cyc < last) step();
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a[11:0]] = b;
    mdl[a] = b;
  endtask

  task automatic issue_if(input logic [31:0] a);
    if_req = 1'b1;
    if_addr = a;
  endtask

  task automatic issue_mem(input bit we, input logic [31:0] a, input int len,
                           input logic [31:0] wd);
    mem_req = 1'b1;
    mem_we = we;
    mem_addr = a;
    mem_len = 3'(len);
    mem_wdata = wd;
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    chk({tag, "_if_done"}, 32'(if_done), 32'd0);
    chk({tag, "_mem_done"}, 32'(mem_done), 32'd0);
    chk({tag, "_ram_wr"}, 32'(ram_wr), 32'd0);
    chk({tag, "_ram_a"}, ram_a, 32'd0);
    chk({tag, "_ram_dout"}, 32'(ram_dout), 32'd0);
    chk({tag, "_if_data"}, if_data, 32'd0);
    chk({tag, "_mem_rdata"}, mem_rdata, 32'd0);
  endtask

  initial begin
    int c0, c0i, dc, dci;
    logic [31:0] d, di;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    step();
    step();
    check_zero("reset");
    rst = 1'b0;
    chk_on = 1'b1;
    step();
    step();

    // Fetch 0x100
    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h00); preload(32'h103, 8'h00);
    issue_if(32'h100);
    c0 = cyc + 1;
    sched(c0, 1'b1, 1'b0, 32'h100, 4, 32'd0, 0, 0, 0, dc, d);
    chk("pin_fetch_latency", 32'(dc - c0), 32'd5);
    chk("pin_fetch_data", d, 32'h00000513);
    if_drop = dc + 1;
    run_to(dc + 2);

    // SW 0x11223344 @ 0x200
    issue_mem(1'b1, 32'h200, 4, 32'h11223344);
    c0 = cyc + 1;
    sched(c0, 1'b0, 1'b1, 32'h200, 4, 32'h11223344, 0, 0, 0, dc, d);
    chk("pin_sw_latency", 32'(dc - c0), 32'd4);
    mem_drop = dc + 1;
    run_to(dc + 2);

    // LB @ 0x3 with if_flush high throughout (must not disturb MEM)
    preload(32'h3, 8'hF0);
    if_flush = 1'b1;
    issue_mem(1'b0, 32'h3, 1, 32'd0);
    c0 = cyc + 1;
    sched(c0, 1'b0, 1'b0, 32'h3, 1, 32'd0, 0, 0, 0, dc, d);
    chk("pin_lb_latency", 32'(dc - c0), 32'd2);
    chk("pin_lb_data", d, 32'h000000F0);
    mem_drop = dc + 1;
    run_to(dc + 1);
    if_flush = 1'b0;
    run_to(dc + 2);

    // Simultaneous requests: MEM first, IF in the IDLE cycle after mem_done
    preload(32'h10, 8'hAB);
    issue_mem(1'b0, 32'h10, 1, 32'd0);
    issue_if(32'h100);
    c0 = cyc + 1;
    sched(c0, 1'b0, 1'b0, 32'h10, 1, 32'd0, 0, 0, 0, dc, d);
    c0i = dc + 2;
    sched(c0i, 1'b1, 1'b0, 32'h100, 4, 32'd0, 0, 0, 0, dci, di);
    chk("pin_prio_gap", 32'(c0i - c0), 32'd4);
    chk("pin_prio_mem_data", d, 32'h000000AB);
    mem_drop = dc + 1;
    if_drop = dci + 1;
    run_to(dci + 2);

    // Flush on cycle 2 of a fetch, then a new fetch accepted from IDLE
    preload(32'h104, 8'h93); preload(32'h105, 8'h00);
    preload(32'h106, 8'h10); preload(32'h107, 8'h00);
    issue_if(32'h100);
    c0 = cyc + 1;
    for (int j = 0; j < 3; j++) begin
      e_achk[c0 + j] = 1'b1;
      e_a[c0 + j] = 32'h100 + 32'(j);
    end
    run_to(c0 + 2);
    if_flush = 1'b1;
    run_to(c0 + 3);
    if_flush = 1'b0;
    if_addr = 32'h104;
    sched(c0 + 4, 1'b1, 1'b0, 32'h104, 4, 32'd0, 0, 0, 0, dc, d);
    chk("pin_refetch_latency", 32'(dc - c0), 32'd9);
    chk("pin_refetch_data", d, 32'h00100093);
    if_drop = dc + 1;
    run_to(dc + 2);

    // SB to IO space with io_buffer_full high for 3 cycles
    issue_mem(1'b1, 32'h00030000, 1, 32'h0000005A);
    c0 = cyc + 1;
    sched(c0, 1'b0, 1'b1, 32'h00030000, 1, 32'h0000005A, 2, 0, 3, dc, d);
    chk("pin_io_latency", 32'(dc - c0), 32'd4);
    mem_drop = dc + 1;
    run_to(dc + 2);

    // LH with rdy low for 2 cycles mid-load
    preload(32'h400, 8'h34); preload(32'h401, 8'h12);
    issue_mem(1'b0, 32'h400, 2, 32'd0);
    c0 = cyc + 1;
    sched(c0, 1'b0, 1'b0, 32'h400, 2, 32'd0, 1, 1, 2, dc, d);
    chk("pin_rdy_latency", 32'(dc - c0), 32'd5);
    chk("pin_rdy_data", d, 32'h00001234);
    mem_drop = dc + 1;
    run_to(dc + 2);

    // LH across the 32-bit address wrap
    preload(32'hFFFFFFFF, 8'h77); preload(32'h0, 8'h66);
    issue_mem(1'b0, 32'hFFFFFFFF, 2, 32'd0);
    c0 = cyc + 1;
    sched(c0, 1'b0, 1'b0, 32'hFFFFFFFF, 2, 32'd0, 0, 0, 0, dc, d);
    chk("pin_wrap_data", d, 32'h00006677);
    mem_drop = dc + 1;
    run_to(dc + 2);

    // Reset pulsed mid-fetch: no if_done, all outputs cleared
    issue_if(32'h100);
    c0 = cyc + 1;
    for (int j = 0; j < 2; j++) begin
      e_achk[c0 + j] = 1'b1;
      e_a[c0 + j] = 32'h100 + 32'(j);
    end
    run_to(c0 + 2);
    rst = 1'b1;
    if_req = 1'b0;
    check_zero("rst_mid");
    step();
    step();
    rst = 1'b0;
    run_to(cyc + 8);

    // Recovery after reset
    issue_mem(1'b0, 32'h3, 1, 32'd0);
    c0 = cyc + 1;
    sched(c0, 1'b0, 1'b0, 32'h3, 1, 32'd0, 0, 0, 0, dc, d);
    chk("pin_recover_data", d, 32'h000000F0);
    mem_drop = dc + 1;
    run_to(dc + 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
